// File: rtl/aes_gcm_pkg.sv
// aes_gcm_pkg: shared state encoding, widths and interim crypto functions
// for the streaming decrypt stage.
package aes_gcm_pkg;

  localparam int DEF_DW      = 32;
  localparam int DEF_KEY_W   = 256;
  localparam int DEF_IV_W    = 256;
  localparam int DEF_LEN_W   = 16;
  localparam int DEF_TIMEOUT = 100;
  localparam int DEF_DEPTH   = 64;
  localparam int MAX_W       = 128;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAG,
    DONE
  } state_t;

  // Interim keystream until the AES core lands: base XOR word index.
  function automatic logic [MAX_W-1:0] ks(
    input logic [MAX_W-1:0] base,
    input logic [MAX_W-1:0] index
  );
    return base ^ index;
  endfunction

  function automatic logic [MAX_W-1:0] tag_calc(
    input logic [MAX_W-1:0] acc,
    input logic [MAX_W-1:0] tkey
  );
    return acc ^ tkey;
  endfunction

endpackage

// File: rtl/gcm_hold_fifo.sv
// gcm_hold_fifo: show-ahead synchronous FIFO with a single-cycle flush,
// holding plaintext until the frame tag has been checked.
module gcm_hold_fifo #(
  parameter int DW = 32,
  parameter int DEPTH = 64,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;

  assign wr = wr_en && !full;
  assign rd = rd_en && !empty;
  assign empty = count == '0;
  assign full = count == (AW + 1)'(DEPTH);
  assign rd_data = mem[rp];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= nxt(wp);
      if (rd) rp <= nxt(rp);
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wr_data;
  end

endmodule

// File: rtl/aes_gcm_stream_decrypt.sv
// aes_gcm_stream_decrypt: framed decrypt, XOR keystream, running-XOR tag.
// Define AES_GCM_TAG_GATE_EN to hold plaintext until the tag verifies.
module aes_gcm_stream_decrypt
  import aes_gcm_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int KEY_W = DEF_KEY_W,
  parameter int IV_W = DEF_IV_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [IV_W-1:0]  iv,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic             m_last,
  input  logic [DW-1:0]    tag_in,
  input  logic             tag_in_valid,
  output logic             busy,
  output logic             done,
  output logic             tag_ok,
  output logic             tag_err,
  output logic             timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t state, state_next;
  logic [DW-1:0] ks_base, tag_key, acc, pt, exp_tag;
  logic [LEN_W-1:0] len, index;
  logic [CW-1:0] idle_cnt;
  logic [MAX_W-1:0] base_w, idx_w, acc_w, key_w, ks_w, tg_w;
  logic beat, tag_take, tag_match, accept, to_hit, last_idx, active;
  logic hold_ok, rel, reject, tag_fin;
  logic unused_ok;

  assign active = (state == DATA) || (state == TAG);
  assign last_idx = index == len - LEN_W'(1);
  assign beat = s_valid && s_ready;
  assign tag_take = (state == TAG) && tag_in_valid && !m_valid && !rel;
  assign tag_match = tag_in == exp_tag;
  assign accept = beat || tag_take;
  assign to_hit = active && !rel && !accept &&
                  (idle_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign unused_ok = ^{key, iv, ks_w, tg_w, DEPTH[0]};

  always_comb begin
    base_w = '0;
    idx_w = '0;
    acc_w = '0;
    key_w = '0;
    base_w[DW-1:0] = ks_base;
    idx_w[LEN_W-1:0] = index;
    acc_w[DW-1:0] = acc;
    key_w[DW-1:0] = tag_key;
    ks_w = ks(base_w, idx_w);
    tg_w = tag_calc(acc_w, key_w);
    pt = s_data ^ ks_w[DW-1:0];
    exp_tag = tg_w[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (reject) state_next = DONE;
          else if (frame_len == '0) state_next = TAG;
          else state_next = DATA;
        end
      end
      DATA: begin
        if (to_hit) state_next = DONE;
        else if (beat && last_idx) state_next = TAG;
      end
      TAG: if (to_hit || tag_fin) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    s_ready = (state == DATA) && hold_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ks_base <= '0;
      tag_key <= '0;
      len <= '0;
      index <= '0;
      acc <= '0;
      idle_cnt <= '0;
      tag_ok <= 1'b0;
      tag_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        ks_base <= key[DW-1:0] ^ iv[DW-1:0];
        tag_key <= key[DW-1:0];
        len <= frame_len;
        index <= '0;
        acc <= '0;
        tag_ok <= 1'b0;
        tag_err <= reject;
        timeout_err <= 1'b0;
      end
      if (beat) begin
        acc <= acc ^ s_data;
        index <= index + LEN_W'(1);
      end
      // Acceptance always clears, even on the threshold cycle.
      if (active && !rel && !accept) idle_cnt <= idle_cnt + CW'(1);
      else idle_cnt <= '0;
      if (tag_take) begin
        tag_ok <= tag_match;
        tag_err <= !tag_match;
      end
      if (to_hit) begin
        timeout_err <= 1'b1;
        tag_ok <= 1'b0;
        tag_err <= 1'b0;
      end
    end
  end

`ifdef AES_GCM_TAG_GATE_EN
  localparam int FAW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int FCW = FAW + 1;

  logic f_empty, f_full, f_pop, f_flush;
  logic [FAW:0] f_cnt;
  logic [DW-1:0] f_data;

  assign reject = int'(frame_len) > DEPTH;
  assign hold_ok = !f_full;
  assign f_pop = m_valid && m_ready;
  assign f_flush = (state == IDLE && start) ||
                   (tag_take && !tag_match) || to_hit;
  assign tag_fin = (tag_take && !tag_match) ||
                   (rel && (f_empty || (f_pop && f_cnt == FCW'(1))));
  assign m_valid = rel && !f_empty;
  assign m_last = m_valid && (f_cnt == FCW'(1));
  assign m_data = m_valid ? f_data : '0;

  // Release phase: tag matched, drain the held words to m_*.
  always_ff @(posedge clk) begin
    if (reset) rel <= 1'b0;
    else if (tag_take && tag_match) rel <= 1'b1;
    else if (state == DONE) rel <= 1'b0;
  end

  gcm_hold_fifo #(
    .DW(DW),
    .DEPTH(DEPTH)
  ) u_hold (
    .clk(clk),
    .reset(reset),
    .flush(f_flush),
    .wr_en(beat),
    .wr_data(pt),
    .rd_en(f_pop),
    .rd_data(f_data),
    .empty(f_empty),
    .full(f_full),
    .count(f_cnt)
  );
`else
  assign reject = 1'b0;
  assign rel = 1'b0;
  assign tag_fin = tag_take;
  assign hold_ok = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data <= '0;
      m_last <= 1'b0;
    end else if (to_hit) begin
      m_valid <= 1'b0;
      m_last <= 1'b0;
    end else if (beat) begin
      m_valid <= 1'b1;
      m_data <= pt;
      m_last <= last_idx;
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_last <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_aes_gcm_stream_decrypt.sv
// tb_aes_gcm_stream_decrypt: directed and random frames, scoreboarded
// against a word-level reference model of the decrypt and tag rules.
module tb_aes_gcm_stream_decrypt;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic reset, start;
  logic [255:0] key, iv;
  logic [15:0] frame_len;
  logic s_valid, s_ready;
  logic [31:0] s_data;
  logic m_valid, m_ready, m_last;
  logic [31:0] m_data;
  logic [31:0] tag_in;
  logic tag_in_valid;
  logic busy, done, tag_ok, tag_err, timeout_err;

  beat_t exp_q[$];
  int n_checks = 0, n_fail = 0;
  int mon_checks = 0, mon_fail = 0, done_cnt = 0;
  bit rand_ready = 1'b0;
  bit fixed_ready = 1'b1;

  aes_gcm_stream_decrypt dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .iv(iv),
    .frame_len(frame_len), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .tag_in(tag_in),
    .tag_in_valid(tag_in_valid), .busy(busy), .done(done),
    .tag_ok(tag_ok), .tag_err(tag_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Plaintext = ct ^ key ^ iv ^ word number (low 32 bits).
  function automatic logic [31:0] ref_pt(input logic [255:0] k, v,
                                         input logic [31:0] ct, input int i);
    return ct ^ k[31:0] ^ v[31:0] ^ 32'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
    end
  end

  initial begin
    beat_t e;
    bit stalled;
    logic [31:0] hd;
    logic hl;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (reset) stalled = 1'b0;
      else begin
        if (stalled) begin
          mon_checks++;
          if (!m_valid || m_data !== hd || m_last !== hl) begin
            mon_fail++;
            $display("FAIL stall hold: got v=%0b d=%h l=%0b expected v=1 d=%h l=%0b",
                     m_valid, m_data, m_last, hd, hl);
          end
        end
        if (m_valid && m_ready) begin
          stalled = 1'b0;
          mon_checks++;
          if (exp_q.size() == 0) begin
            mon_fail++;
            $display("FAIL unexpected output: got d=%h l=%0b expected none",
                     m_data, m_last);
          end else begin
            e = exp_q.pop_front();
            if ({m_data, m_last} !== e) begin
              mon_fail++;
              $display("FAIL plaintext: got d=%h l=%0b expected d=%h l=%0b",
                       m_data, m_last, e.d, e.l);
            end
          end
        end else if (m_valid) begin
          stalled = 1'b1;
          hd = m_data;
          hl = m_last;
        end else stalled = 1'b0;
      end
    end
  end

  task automatic do_start(input logic [255:0] k, v, input logic [15:0] len);
    int i = 0;
    while (busy && i < 500) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("idle before start", busy, 0);
    key = k;
    iv = v;
    frame_len = len;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    bit got = 1'b0;
    s_valid = 1'b1;
    s_data = d;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    chk("word handshake", got, 1);
  endtask

  task automatic send_tag(input logic [31:0] t);
    int i = 0;
    while (m_valid && i < 500) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("last word drained", m_valid, 0);
    tag_in = t;
    tag_in_valid = 1'b1;
    @(posedge clk);
    #1;
    tag_in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit ok, err, to);
    bit seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk({name, " done"}, seen, 1);
    chk({name, " flags"}, {tag_ok, tag_err, timeout_err}, {ok, err, to});
    @(posedge clk);
    #1;
    chk({name, " done one cycle"}, {done, busy}, 0);
  endtask

  task automatic run_rand(input int n);
    logic [255:0] k, v;
    logic [31:0] ct, tg;
    int len;
    bit good;
    k = rnd256();
    v = rnd256();
    len = $urandom_range(1, 8);
    good = $urandom_range(0, 3) != 0;
    tg = k[31:0];
    do_start(k, v, 16'(len));
    for (int i = 0; i < len; i++) begin
      ct = $urandom;
      tg ^= ct;
      exp_q.push_back({ref_pt(k, v, ct, i), i == len - 1});
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send_word(ct);
    end
    send_tag(good ? tg : tg ^ (32'h1 << $urandom_range(0, 31)));
    wait_done($sformatf("rand%0d", n), good, !good, 1'b0);
  endtask

  initial begin
    logic [255:0] k0, v0, k1, v1;
    logic [31:0] ct, tg;
    int d0, n;
    reset = 1'b1;
    start = 1'b0;
    key = '0;
    iv = '0;
    frame_len = '0;
    s_valid = 1'b0;
    s_data = '0;
    tag_in = '0;
    tag_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {s_ready, m_valid, m_data, m_last, busy, done,
                          tag_ok, tag_err, timeout_err}, 0);
    reset = 1'b0;

    k0 = rnd256();
    k0[31:0] = 32'hA5A5A5A5;
    v0 = rnd256();
    v0[31:0] = 32'h0F0F0F0F;

    d0 = done_cnt;
    do_start(k0, v0, 16'd2);
    exp_q.push_back({32'h0000AAAA, 1'b0});
    exp_q.push_back({32'hAAAAAAAA, 1'b1});
    send_word(32'hAAAA0000);
    send_word(32'h00000001);
    send_tag(32'h0F0FA5A4);
    wait_done("basic", 1'b1, 1'b0, 1'b0);
    chk("basic done count", done_cnt - d0, 1);

    do_start(k0, v0, 16'd2);
    exp_q.push_back({32'h0000AAAA, 1'b0});
    exp_q.push_back({32'hAAAAAAAA, 1'b1});
    send_word(32'hAAAA0000);
    send_word(32'h00000001);
    send_tag(32'h0F0FA5A5);
    wait_done("wrong tag", 1'b0, 1'b1, 1'b0);

    do_start(k0, v0, 16'd2);
    exp_q.push_back({32'h0000AAAA, 1'b0});
    exp_q.push_back({32'hAAAAAAAA, 1'b1});
    fixed_ready = 1'b0;
    send_word(32'hAAAA0000);
    s_valid = 1'b1;
    s_data = 32'h00000001;
    repeat (5) begin
      @(negedge clk);
      chk("bp s_ready", s_ready, 0);
      chk("bp m_data", {m_valid, m_data}, {1'b1, 32'h0000AAAA});
    end
    @(posedge clk);
    #1;
    fixed_ready = 1'b1;
    send_word(32'h00000001);
    send_tag(32'h0F0FA5A4);
    wait_done("backpressure", 1'b1, 1'b0, 1'b0);

    do_start(k0, v0, 16'd3);
    exp_q.push_back({32'h0000AAAA, 1'b0});
    send_word(32'hAAAA0000);
    n = 0;
    while (!timeout_err && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("timeout idle cycles", n, 100);
    wait_done("timeout", 1'b0, 1'b0, 1'b1);

    do_start(k0, v0, 16'd0);
    chk("start clears flags", {timeout_err, tag_ok, tag_err, busy}, 4'b0001);
    send_tag(32'hA5A5A5A5);
    wait_done("len0", 1'b1, 1'b0, 1'b0);

    k1 = rnd256();
    v1 = rnd256();
    do_start(k1, v1, 16'd4);
    tg = k1[31:0];
    for (int i = 0; i < 4; i++) begin
      ct = $urandom;
      tg ^= ct;
      exp_q.push_back({ref_pt(k1, v1, ct, i), i == 3});
      if (i == 2) begin
        start = 1'b1;
        key = rnd256();
        iv = rnd256();
        frame_len = 16'd9;
      end
      send_word(ct);
    end
    start = 1'b0;
    send_tag(tg);
    wait_done("start ignored", 1'b1, 1'b0, 1'b0);

    do_start(k1, v1, 16'd3);
    ct = $urandom;
    exp_q.push_back({ref_pt(k1, v1, ct, 0), 1'b0});
    send_word(ct);
    @(posedge clk);
    #1;
    d0 = done_cnt;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid-frame reset outputs", {s_ready, m_valid, m_data, m_last, busy,
                                    done, tag_ok, tag_err, timeout_err}, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no done after reset", done_cnt - d0, 0);
    chk("idle after reset", busy, 0);
    chk("queue after reset", exp_q.size(), 0);

    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) run_rand(i);
    rand_ready = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard empty", exp_q.size(), 0);
    n_checks += mon_checks;
    n_fail += mon_fail;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

endmodule
